// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider.
//   state_t   : controller state encoding
//   cnt_width : width of the bit counter needed to count n restoring steps
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/signed_or_unsigned_div_if.sv
// Operand/result handshake bundle for signed_or_unsigned_div.
//   master : producer of operands and consumer of results (e.g. testbench)
//   slave  : the divider
// div_by_zero exists only when DIV_BY_ZERO_FLAG_EN is defined.
interface signed_or_unsigned_div_if #(parameter int n = 8);
  logic [n-1:0] a;
  logic [n-1:0] b;
  logic         signed_div;
  logic         arg_vld;
  logic         arg_rdy;
  logic [n-1:0] quo;
  logic [n-1:0] rem;
  logic         res_vld;
  logic         res_rdy;
`ifdef DIV_BY_ZERO_FLAG_EN
  logic         div_by_zero;

  modport master (
    output a, b, signed_div, arg_vld, res_rdy,
    input  arg_rdy, quo, rem, res_vld, div_by_zero
  );
  modport slave (
    input  a, b, signed_div, arg_vld, res_rdy,
    output arg_rdy, quo, rem, res_vld, div_by_zero
  );
`else
  modport master (
    output a, b, signed_div, arg_vld, res_rdy,
    input  arg_rdy, quo, rem, res_vld
  );
  modport slave (
    input  a, b, signed_div, arg_vld, res_rdy,
    output arg_rdy, quo, rem, res_vld
  );
`endif
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step.
//   prem     : partial remainder entering the step (always < dvs)
//   dvd_bit  : next dividend bit, shifted in at the LSB
//   dvs      : divisor magnitude
//   prem_nxt : partial remainder leaving the step
//   q_bit    : quotient bit produced by the step
module div_step #(
  parameter int n = 8
) (
  input  logic [n-1:0] prem,
  input  logic         dvd_bit,
  input  logic [n-1:0] dvs,
  output logic [n-1:0] prem_nxt,
  output logic         q_bit
);
  logic [n:0]   shifted;
  logic [n-1:0] diff;

  assign shifted = {prem, dvd_bit};
  assign q_bit   = (shifted >= {1'b0, dvs});
  // When the subtraction succeeds the exact difference is below dvs, so the
  // low n bits of a modular subtract are the whole answer.
  assign diff     = shifted[n-1:0] - dvs;
  assign prem_nxt = q_bit ? diff : shifted[n-1:0];
endmodule

// File: rtl/signed_or_unsigned_div.sv
// Iterative n-bit divider, one restoring step per clock.
// Operands are unsigned or two's complement per signed_div; results truncate
// toward zero with the remainder taking the dividend's sign.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-low reset
//   bus : slave side of signed_or_unsigned_div_if (a, b, signed_div, arg_vld,
//         arg_rdy, quo, rem, res_vld, res_rdy, div_by_zero)
// Build option: DIV_BY_ZERO_FLAG_EN adds the registered div_by_zero output.
//
// state | meaning
// IDLE  | waiting for operands, arg_rdy high
// CALC  | n restoring steps, one per cycle
// FIX   | sign correction and special cases, load quo/rem
// DONE  | result held until res_rdy (res_vld rises one cycle after entry)
module signed_or_unsigned_div
  import div_pkg::*;
#(
  parameter int n = 8
) (
  input logic                      clk,
  input logic                      rst,
  signed_or_unsigned_div_if.slave  bus
);
  localparam int CW = cnt_width(n);

  state_t       state, state_nxt;
  logic [CW-1:0] cnt;
  logic [n-1:0] dvd, dvs, a_orig, prem, q_acc;
  logic         a_neg, q_neg, b_zero;
  logic [n-1:0] prem_nxt;
  logic         q_bit;
  logic         a_sgn, b_sgn;
  logic [n-1:0] quo_fix, rem_fix;
  logic [n-1:0] quo_r, rem_r;
  logic         arg_rdy_r, res_vld_r;
  logic         accept, res_take;

  assign accept   = (state == IDLE) && bus.arg_vld && arg_rdy_r;
  assign res_take = res_vld_r && bus.res_rdy;
  assign a_sgn    = bus.signed_div && bus.a[n-1];
  assign b_sgn    = bus.signed_div && bus.b[n-1];

  div_step #(.n(n)) u_step (
    .prem     (prem),
    .dvd_bit  (dvd[n-1]),
    .dvs      (dvs),
    .prem_nxt (prem_nxt),
    .q_bit    (q_bit)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = CALC;
      CALC: if (cnt == CW'(n - 1)) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: if (res_take) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Magnitudes are plain n-bit values, so |most negative| needs no extra bit
  // and the overflow case (most negative / -1) wraps back to a by itself.
  always_comb begin
    quo_fix = q_acc;
    rem_fix = prem;
    if (b_zero) begin
      quo_fix = '1;
      rem_fix = a_orig;
    end else begin
      if (q_neg) quo_fix = ~q_acc + n'(1);
      if (a_neg) rem_fix = ~prem + n'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      arg_rdy_r <= 1'b0;
      res_vld_r <= 1'b0;
      quo_r     <= '0;
      rem_r     <= '0;
      cnt       <= '0;
      dvd       <= '0;
      dvs       <= '0;
      a_orig    <= '0;
      prem      <= '0;
      q_acc     <= '0;
      a_neg     <= 1'b0;
      q_neg     <= 1'b0;
      b_zero    <= 1'b0;
    end else begin
      arg_rdy_r <= (state_nxt == IDLE);
      // One bubble cycle in DONE before res_vld, giving accept-to-valid n+2.
      res_vld_r <= (state == DONE) && !res_take;
      case (state)
        IDLE: if (accept) begin
          dvd    <= a_sgn ? ~bus.a + n'(1) : bus.a;
          dvs    <= b_sgn ? ~bus.b + n'(1) : bus.b;
          a_orig <= bus.a;
          a_neg  <= a_sgn;
          q_neg  <= a_sgn ^ b_sgn;
          b_zero <= (bus.b == '0);
          prem   <= '0;
          q_acc  <= '0;
          cnt    <= '0;
        end
        CALC: begin
          prem  <= prem_nxt;
          q_acc <= {q_acc[n-2:0], q_bit};
          dvd   <= {dvd[n-2:0], 1'b0};
          cnt   <= (cnt == CW'(n - 1)) ? '0 : cnt + CW'(1);
        end
        FIX: begin
          quo_r <= quo_fix;
          rem_r <= rem_fix;
        end
        default: ;
      endcase
    end
  end

  assign bus.arg_rdy = arg_rdy_r;
  assign bus.res_vld = res_vld_r;
  assign bus.quo     = quo_r;
  assign bus.rem     = rem_r;

`ifdef DIV_BY_ZERO_FLAG_EN
  logic dbz_r;

  always_ff @(posedge clk) begin
    if (!rst)                 dbz_r <= 1'b0;
    else if (accept)          dbz_r <= 1'b0;
    else if (state == FIX)    dbz_r <= b_zero;
  end

  assign bus.div_by_zero = dbz_r;
`endif
endmodule
